// File: rtl/pkt_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the MAC TX packet port.
// Optional packet-length watchdog with drain state: define PKT_TX_ARB_WDOG_EN.

module pkt_tx_arb_lane (
  input  logic val,
  input  logic sop,
  input  logic idle,
  input  logic own,
  input  logic own_rdy,
  output logic cand,
  output logic orphan,
  output logic rdy
);
  // Any non-sop word not belonging to the packet in flight is swallowed.
  assign cand   = val & sop & idle;
  assign orphan = val & ~sop & ~own;
  assign rdy    = orphan | (own & own_rdy);
endmodule

module pkt_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_W     = 1,
  parameter int MAX_WORDS = 1200
) (
  input  logic                   clk_156m25,
  input  logic                   reset_156m25,
  input  logic [NUM_REQ-1:0]     req_val,
  input  logic [NUM_REQ-1:0]     req_sop,
  input  logic [NUM_REQ-1:0]     req_eop,
  input  logic [3*NUM_REQ-1:0]   req_mod,
  input  logic [64*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_rdy,
  output logic [63:0]            pkt_tx_data,
  output logic                   pkt_tx_val,
  output logic                   pkt_tx_sop,
  output logic                   pkt_tx_eop,
  output logic [2:0]             pkt_tx_mod,
  input  logic                   pkt_tx_full,
  output logic                   arb_busy,
  output logic [IDX_W-1:0]       arb_grant_idx,
  output logic [15:0]            drop_cnt
);
`ifdef PKT_TX_ARB_WDOG_EN
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

  state_t state_q, state_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d, grant_d, sel_idx, hi_idx, lo_idx, nxt_ptr;
  logic hi_found, lo_found;
  logic [NUM_REQ-1:0] cand, orphan, own;
  logic [NUM_REQ-1:0][63:0] data_a;
  logic [NUM_REQ-1:0][2:0]  mod_a;
  logic own_rdy, tx_fire, drain_fire, wdog_cut;
  logic [3:0]  drop_inc;
  logic [16:0] drop_sum;

  assign data_a   = req_data;
  assign mod_a    = req_mod;
  assign arb_busy = (state_q != IDLE);
  assign own_rdy  = (state_q == XFER) ? ~pkt_tx_full : 1'b1;
  assign tx_fire  = (state_q == XFER) & req_val[arb_grant_idx] & ~pkt_tx_full;
  assign nxt_ptr  = (arb_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_grant_idx + 1'b1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign own[i] = arb_busy & (arb_grant_idx == IDX_W'(i));
    pkt_tx_arb_lane u_lane (
      .val(req_val[i]), .sop(req_sop[i]), .idle(state_q == IDLE), .own(own[i]),
      .own_rdy(own_rdy), .cand(cand[i]), .orphan(orphan[i]), .rdy(req_rdy[i])
    );
  end

`ifdef PKT_TX_ARB_WDOG_EN
  logic [15:0] wcnt;
  assign drain_fire = (state_q == DRAIN) & req_val[arb_grant_idx];
  assign wdog_cut   = tx_fire & ~req_eop[arb_grant_idx] & (wcnt == 16'(MAX_WORDS-1));
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25 || state_q == IDLE) wcnt <= '0;
    else if (tx_fire)                    wcnt <= wcnt + 16'd1;
  end
`else
  assign drain_fire = 1'b0;
  assign wdog_cut   = 1'b0;
`endif

  // Round robin: lowest candidate at/above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0; lo_found = 1'b0; hi_idx = '0; lo_idx = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (cand[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr;
    grant_d  = arb_grant_idx;
    case (state_q)
      IDLE: if (lo_found) begin
        state_d = XFER;
        grant_d = sel_idx;
      end
      XFER: if (tx_fire) begin
        if (req_eop[arb_grant_idx]) begin
          state_d  = IDLE;
          rr_ptr_d = nxt_ptr;
        end
`ifdef PKT_TX_ARB_WDOG_EN
        else if (wdog_cut) state_d = DRAIN;
`endif
      end
`ifdef PKT_TX_ARB_WDOG_EN
      DRAIN: if (drain_fire && req_eop[arb_grant_idx]) begin
        state_d  = IDLE;
        rr_ptr_d = nxt_ptr;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state_q       <= IDLE;
      rr_ptr        <= '0;
      arb_grant_idx <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr        <= rr_ptr_d;
      arb_grant_idx <= grant_d;
    end
  end

  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NUM_REQ; i++) drop_inc = drop_inc + 4'(orphan[i]);
    drop_inc = drop_inc + 4'(drain_fire);
  end
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

  // Idle cycles keep data/mod but never repeat a sop/eop marker.
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
      drop_cnt    <= '0;
    end else begin
      pkt_tx_val <= tx_fire;
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (tx_fire) begin
        pkt_tx_data <= data_a[arb_grant_idx];
        pkt_tx_sop  <= req_sop[arb_grant_idx];
        pkt_tx_eop  <= req_eop[arb_grant_idx] | wdog_cut;
        pkt_tx_mod  <= wdog_cut ? 3'd0 : mod_a[arb_grant_idx];
      end else begin
        pkt_tx_sop <= 1'b0;
        pkt_tx_eop <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pkt_tx_arbiter.sv
// Scoreboard bench for pkt_tx_arbiter: directed packets, expected words queued
// up front, a monitor pops and compares every pkt_tx_val word.
module tb_pkt_tx_arbiter;
  localparam int NR = 2;
  localparam int IW = 1;
`ifdef PKT_TX_ARB_WDOG_EN
  localparam int MW = 4;
`else
  localparam int MW = 1200;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]    req_val, req_sop, req_eop, req_rdy;
  logic [3*NR-1:0]  req_mod;
  logic [64*NR-1:0] req_data;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full, arb_busy;
  logic [2:0]  pkt_tx_mod;
  logic [IW-1:0] arb_grant_idx;
  logic [15:0] drop_cnt;

  logic v [NR];
  logic s [NR];
  logic e [NR];
  logic [2:0]  md [NR];
  logic [63:0] d  [NR];

  typedef struct {
    logic [63:0]   data;
    logic          sop;
    logic          eop;
    logic [2:0]    mod;
    logic [IW-1:0] idx;
  } exp_t;
  exp_t q[$];
  exp_t mon_x;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_val = '0; req_sop = '0; req_eop = '0; req_mod = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req_val[i] = v[i];
      req_sop[i] = s[i];
      req_eop[i] = e[i];
      req_mod[3*i +: 3]   = md[i];
      req_data[64*i +: 64] = d[i];
    end
  end

  pkt_tx_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .MAX_WORDS(MW)) dut (
    .clk_156m25(clk), .reset_156m25(rst),
    .req_val(req_val), .req_sop(req_sop), .req_eop(req_eop), .req_mod(req_mod),
    .req_data(req_data), .req_rdy(req_rdy),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .arb_busy(arb_busy), .arb_grant_idx(arb_grant_idx), .drop_cnt(drop_cnt)
  );

  function automatic logic [63:0] mkdata(input int r, input int p, input int w);
    return {16'hC0DE, 24'h0, 8'(r), 8'(p), 8'(w)};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input int r, input int p, input int w, input logic sp,
                           input logic ep, input logic [2:0] m);
    exp_t x;
    x.data = mkdata(r, p, w); x.sop = sp; x.eop = ep; x.mod = m; x.idx = IW'(r);
    q.push_back(x);
  endtask

  task automatic push_pkt(input int r, input int p, input int n, input logic [2:0] m);
    for (int w = 0; w < n; w++)
      push_word(r, p, w, w == 0, w == n-1, (w == n-1) ? m : 3'd0);
  endtask

  // Present one packet word by word, advancing only on req_rdy.
  task automatic send_pkt(input int r, input int p, input int n, input logic [2:0] m);
    for (int w = 0; w < n; w++) begin
      int budget;
      bit done;
      budget = 0; done = 0;
      v[r] = 1'b1; s[r] = (w == 0); e[r] = (w == n-1);
      md[r] = (w == n-1) ? m : 3'd0; d[r] = mkdata(r, p, w);
      while (!done) begin
        @(negedge clk);
        if (req_rdy[r]) done = 1;
        else if (++budget > 200) begin
          total++; bad++; done = 1;
          $display("FAIL send_timeout: req %0d word %0d not accepted in 200 cycles", r, w);
        end
        @(posedge clk); #1;
      end
    end
    v[r] = 1'b0; s[r] = 1'b0; e[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; pkt_tx_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v[i] = 0; s[i] = 0; e[i] = 0; md[i] = '0; d[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset();

    fork
      forever begin
        @(negedge clk);
        if (pkt_tx_val) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got data=%0h sop=%0b eop=%0b expected no word",
                     pkt_tx_data, pkt_tx_sop, pkt_tx_eop);
          end else begin
            mon_x = q.pop_front();
            chk("tx_word", 80'({pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, arb_grant_idx}),
                80'({mon_x.data, mon_x.sop, mon_x.eop, mon_x.mod, mon_x.idx}));
          end
        end
      end
    join_none

    // reset state
    @(negedge clk);
    chk("rst_val",   80'(pkt_tx_val), 80'(0));
    chk("rst_sopeop", 80'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}), 80'(0));
    chk("rst_data",  80'(pkt_tx_data), 80'(0));
    chk("rst_busy",  80'(arb_busy), 80'(0));
    chk("rst_grant", 80'(arb_grant_idx), 80'(0));
    chk("rst_drop",  80'(drop_cnt), 80'(0));
    chk("rst_rdy",   80'(req_rdy), 80'(0));
    @(posedge clk); #1;

    // 3-word packet from req 0: output 2 cycles after first val, 3 beats
    push_pkt(0, 1, 3, 3'd5);
    fork
      send_pkt(0, 1, 3, 3'd5);
      begin
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t1_val_run", 80'(pkt_tx_val), 80'(1));
        end
        @(negedge clk);
        chk("t1_val_end", 80'(pkt_tx_val), 80'(0));
      end
    join
    @(posedge clk); #1;

    // both requesters contend with 2-word packets: 0,1,0,1
    do_reset();
    push_pkt(0, 1, 2, 3'd1);
    push_pkt(1, 1, 2, 3'd2);
    push_pkt(0, 2, 2, 3'd1);
    push_pkt(1, 2, 2, 3'd2);
    fork
      begin send_pkt(0, 1, 2, 3'd1); send_pkt(0, 2, 2, 3'd1); end
      begin send_pkt(1, 1, 2, 3'd2); send_pkt(1, 2, 2, 3'd2); end
    join
    chk("rr_wrap", 80'(dut.rr_ptr), 80'(0));

    // single-word packet (sop+eop together)
    push_pkt(0, 3, 1, 3'd7);
    send_pkt(0, 3, 1, 3'd7);
    chk("single_idle", 80'(arb_busy), 80'(0));

    // backpressure: full for 4 cycles in the middle of a req 1 packet
    push_pkt(1, 4, 5, 3'd3);
    fork
      send_pkt(1, 4, 5, 3'd3);
      begin
        repeat (3) @(posedge clk);
        #1 pkt_tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("full_rdy", 80'(req_rdy[1]), 80'(0));
          if (i > 0) chk("full_gap", 80'(pkt_tx_val), 80'(0));
        end
        @(posedge clk);
        #1 pkt_tx_full = 1'b0;
        @(negedge clk);
        chk("full_gap", 80'(pkt_tx_val), 80'(0));
      end
    join
    repeat (3) @(posedge clk); #1;

    // orphan words from req 1 while idle
    do_reset();
    v[1] = 1'b1; s[1] = 1'b0; e[1] = 1'b0; d[1] = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("orph_rdy", 80'(req_rdy[1]), 80'(1));
      chk("orph_val", 80'(pkt_tx_val), 80'(0));
      @(posedge clk); #1;
    end
    v[1] = 1'b0;
    @(negedge clk);
    chk("orph_drop", 80'(drop_cnt), 80'(3));
    chk("orph_busy", 80'(arb_busy), 80'(0));
    @(posedge clk); #1;

    // reset on word 2 of a 5-word packet
    do_reset();
    push_word(0, 5, 0, 1'b1, 1'b0, 3'd0);
    push_word(0, 5, 1, 1'b0, 1'b0, 3'd0);
    fork
      send_pkt(0, 5, 5, 3'd3);
      begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_val",   80'(pkt_tx_val), 80'(0));
        chk("mid_rst_flags", 80'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}), 80'(0));
        chk("mid_rst_data",  80'(pkt_tx_data), 80'(0));
        chk("mid_rst_busy",  80'(arb_busy), 80'(0));
        chk("mid_rst_state", 80'(dut.state_q), 80'(0));
        chk("mid_rst_rr",    80'(dut.rr_ptr), 80'(0));
        chk("mid_rst_drop",  80'(drop_cnt), 80'(0));
      end
    join
    repeat (3) @(posedge clk); #1;

`ifdef PKT_TX_ARB_WDOG_EN
    // watchdog: 6-word packet truncated after 4 words, rest drained
    do_reset();
    push_word(0, 6, 0, 1'b1, 1'b0, 3'd0);
    push_word(0, 6, 1, 1'b0, 1'b0, 3'd0);
    push_word(0, 6, 2, 1'b0, 1'b0, 3'd0);
    push_word(0, 6, 3, 1'b0, 1'b1, 3'd0);
    push_pkt(1, 6, 1, 3'd4);
    fork
      send_pkt(0, 6, 6, 3'd2);
      send_pkt(1, 6, 1, 3'd4);
    join
    @(negedge clk);
    chk("wdog_drop", 80'(drop_cnt), 80'(2));
    @(posedge clk); #1;
`endif

    repeat (5) @(posedge clk);
    chk("queue_empty", 80'(q.size()), 80'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pkt_tx_arbiter.md
Name: pkt_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the MAC packet transmit interface (pkt_tx_*) among NUM_REQ local packet sources.
- Sits in the clk_156m25 domain, directly in front of the MAC TX packet port.
- Honours pkt_tx_full backpressure and never interleaves words of different packets.
- Discards orphan words that arrive outside a packet.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- IDX_W, 1, width of arb_grant_idx; must be at least clog2(NUM_REQ).
- MAX_WORDS, 1200, watchdog packet-length limit in 64-bit words (used only with PKT_TX_ARB_WDOG_EN).

Ports:
- clk_156m25  in  1  core clock, 156.25 MHz.
- reset_156m25  in  1  reset, synchronous, active-high.
- req_val  in  NUM_REQ  per-requester word valid.
- req_sop  in  NUM_REQ  per-requester start of packet.
- req_eop  in  NUM_REQ  per-requester end of packet.
- req_mod  in  3*NUM_REQ  per-requester valid-byte modulo on eop; requester i uses bits [3i+2:3i].
- req_data  in  64*NUM_REQ  per-requester data; requester i uses bits [64i+63:64i].
- req_rdy  out  NUM_REQ  word accepted this cycle when req_val[i] & req_rdy[i].
- pkt_tx_data  out  64  data to MAC.
- pkt_tx_val  out  1  word valid to MAC.
- pkt_tx_sop  out  1  start of packet to MAC.
- pkt_tx_eop  out  1  end of packet to MAC.
- pkt_tx_mod  out  3  modulo to MAC.
- pkt_tx_full  in  1  MAC TX FIFO almost-full.
- arb_busy  out  1  a packet is in progress.
- arb_grant_idx  out  IDX_W  index of the current/last granted requester.
- drop_cnt  out  16  saturating count of discarded orphan words.

Behaviour:
- Clock and reset: single clock clk_156m25; reset_156m25 is synchronous and active-high.
- Reset values: all outputs 0; round-robin pointer rr_ptr = 0; state IDLE.
- States: IDLE and XFER.
- IDLE, candidates: a requester is a candidate when req_val[i] & req_sop[i].
- IDLE, selection: pick the first candidate at or after rr_ptr, cyclically. Latch its index into arb_grant_idx and go to XFER.
  - No req_rdy is raised in the selecting cycle.
  - Arbitration costs 1 idle cycle per packet.
- IDLE, orphans: a requester with req_val & ~req_sop gets req_rdy=1; the word is discarded and drop_cnt increments (saturates at 0xFFFF).
  - Multiple orphans in the same cycle count once each.
- XFER, ready: req_rdy[g] = ~pkt_tx_full for the granted requester g; every other req_rdy is 0, except that orphan discard applies to non-granted requesters presenting non-sop words.
  - Non-granted requesters presenting sop words wait.
- XFER, transfer: on req_val[g] & req_rdy[g], the word is registered onto the pkt_tx_* outputs with pkt_tx_val=1 in the next cycle. Latency is 1 cycle from input to output.
- XFER, idle outputs: when no transfer occurs, the next-cycle pkt_tx_val=0. data/sop/eop/mod then hold their last values, but sop and eop are forced to 0.
- XFER, sop inside packet: a word with sop inside a packet (no prior eop) is forwarded as-is with sop=1; the arbiter does not repair it.
- End of packet: the transfer with req_eop[g]=1 returns to IDLE and sets rr_ptr = (g+1) mod NUM_REQ.
  - A single-word packet (sop and eop together) is legal: 1 transfer, then IDLE.
- arb_busy = (state == XFER).
- pkt_tx_full: sampled combinationally into req_rdy. The MAC full flag carries at least 1 word of margin, so the single registered word in flight is legal.
  - Full asserted mid-packet stalls the packet; pkt_tx_val gaps are permitted by the MAC.
- pkt_tx_mod: passed through unchanged; meaningful only with eop.
- Reset mid-packet: outputs clear at the next edge; no eop is emitted. The MAC is reset together with the arbiter.

Optional Feature:
- Macro: PKT_TX_ARB_WDOG_EN.
- Enabled:
  - A word counter (16 bits) counts transfers of the current packet.
  - When the MAX_WORDS-th word is transferred without req_eop, that word is output with pkt_tx_eop=1 and pkt_tx_mod=0.
  - The arbiter then enters a DRAIN state: req_rdy[g]=1 regardless of pkt_tx_full, words are discarded and counted in drop_cnt, until the requester's eop word is discarded. It then returns to IDLE with rr_ptr = g+1.
- Disabled: no counter, no DRAIN state; packets of any length pass through.

Test Plan:
- Reset, then req 0 sends a 3-word packet (sop on word 0, eop on word 2, mod=5) -> pkt_tx_val high for 3 cycles starting 2 cycles after the first req_val; sop on word 0, eop+mod=5 on word 2; arb_grant_idx=0.
- Req 0 and req 1 both hold sop continuously, 2-word packets each -> grants alternate 0,1,0,1; no word interleaving; rr_ptr wraps from 1 to 0.
- pkt_tx_full high for 4 cycles mid-packet of req 1 -> req_rdy[1]=0 for those cycles; pkt_tx_val=0 one cycle later for 4 cycles; packet completes intact.
- Req 1 presents 3 non-sop words while idle -> req_rdy[1]=1, nothing on pkt_tx_*, drop_cnt=3.
- Reset asserted on word 2 of a 5-word packet -> next cycle all outputs 0, state IDLE, rr_ptr=0.
- WDOG_EN, MAX_WORDS=4, req 0 sends 6 words -> 4 words out with eop on word 4 and mod=0; 2 words discarded; drop_cnt=2; then req 1 granted.
